// File: rtl/host_reg_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Package     : host_bridge_pkg
// Description : Opcodes, response bytes, FSM encoding and register ids shared
//               by the host command bridge and the register read mux.
// Revision    : 1.0 - initial release
// ============================================================================
package host_bridge_pkg;

    localparam logic [7:0] OP_READ     = 8'h52;
    localparam logic [7:0] OP_WRITE    = 8'h57;
    localparam logic [7:0] ACK_DEFAULT = 8'h06;
    localparam logic [7:0] NAK_DEFAULT = 8'h15;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_ID_HI  = 4'd1,
        ST_ID_LO  = 4'd2,
        ST_D_HI   = 4'd3,
        ST_D_LO   = 4'd4,
        ST_EXEC   = 4'd5,
        ST_TX_HI  = 4'd6,
        ST_TX_LO  = 4'd7,
        ST_TX_RSP = 4'd8
    } state_t;

    localparam logic [15:0] REG_I2C_DATA = 16'h0001;
    localparam logic [15:0] REG_I2C_STAT = 16'h0002;
    localparam logic [15:0] REG_I2C_CTRL = 16'h0003;
    localparam logic [15:0] REG_GPIO_IN  = 16'h0004;
    localparam logic [15:0] REG_GPIO_OUT = 16'h0005;
    localparam logic [15:0] REG_TIMER_LO = 16'h0006;
    localparam logic [15:0] REG_TIMER_HI = 16'h0007;
    localparam logic [15:0] REG_VERSION  = 16'h0008;
    localparam logic [15:0] REG_SYNC     = 16'h0009;

endpackage
`default_nettype wire

// File: rtl/host_reg_bridge_frame_timer.sv
`default_nettype none
// ============================================================================
// Module      : frame_timer
// Description : Saturating inter-byte idle counter; expired when it reaches
//               MAX_COUNT.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_timer #(
    parameter int unsigned MAX_COUNT = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int unsigned W = $clog2(MAX_COUNT + 1);

    logic [W-1:0] r_count;
    logic         w_expired;

    assign w_expired = (r_count == W'(MAX_COUNT));
    assign o_expired = w_expired;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !w_expired) begin
            r_count <= r_count + W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/host_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module      : host_reg_bridge
// Description : Parses host read/write frames from the UART RX byte stream,
//               drives the register bus and returns read data / ACK / NAK.
// Revision    : 1.0 - initial release
// ============================================================================
module host_reg_bridge
    import host_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter logic [7:0]  ACK_BYTE       = ACK_DEFAULT,
    parameter logic [7:0]  NAK_BYTE       = NAK_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] id,
    output logic        read,
    output logic        write,
    output logic [15:0] wdata,
    input  logic [15:0] rdata,
    output logic        error,
    output logic        overrun
);
    state_t      r_state,   w_state_nxt;
    logic        r_is_wr,   w_is_wr_nxt;
    logic [15:0] r_id,      w_id_nxt;
    logic [15:0] r_wdata,   w_wdata_nxt;
    logic [15:0] r_held,    w_held_nxt;
    logic [7:0]  r_tx_data, w_tx_data_nxt;
    logic        r_tx_valid, w_tx_valid_nxt;
    logic        r_error,   w_error_nxt;
    logic        r_overrun, w_overrun_nxt;

    logic w_in_frame;
    logic w_busy;
    logic w_expired;
    logic w_tx_done;

    assign w_in_frame = (r_state inside {ST_ID_HI, ST_ID_LO, ST_D_HI, ST_D_LO});
    assign w_busy     = (r_state inside {ST_EXEC, ST_TX_HI, ST_TX_LO, ST_TX_RSP});
    assign w_tx_done  = r_tx_valid && tx_ready;

    // Clearing on expiry keeps the counter at zero once the frame is dropped.
    frame_timer #(
        .MAX_COUNT (TIMEOUT_CYCLES)
    ) u_frame_timer (
        .clk       (clk),
        .rst       (reset),
        .i_clear   (!w_in_frame || rx_valid || w_expired),
        .i_enable  (w_in_frame),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_is_wr    <= 1'b0;
            r_id       <= '0;
            r_wdata    <= '0;
            r_held     <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_error    <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_is_wr    <= w_is_wr_nxt;
            r_id       <= w_id_nxt;
            r_wdata    <= w_wdata_nxt;
            r_held     <= w_held_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_error    <= w_error_nxt;
            r_overrun  <= w_overrun_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_is_wr_nxt    = r_is_wr;
        w_id_nxt       = r_id;
        w_wdata_nxt    = r_wdata;
        w_held_nxt     = r_held;
        w_tx_data_nxt  = r_tx_data;
        w_tx_valid_nxt = r_tx_valid;
        w_error_nxt    = 1'b0;
        w_overrun_nxt  = r_overrun || (rx_valid && w_busy);

        case (r_state)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == OP_READ || rx_data == OP_WRITE) begin
                        w_is_wr_nxt = (rx_data == OP_WRITE);
                        w_state_nxt = ST_ID_HI;
                    end else begin
                        w_error_nxt    = 1'b1;
                        w_tx_data_nxt  = NAK_BYTE;
                        w_tx_valid_nxt = 1'b1;
                        w_state_nxt    = ST_TX_RSP;
                    end
                end
            end
            // A byte arriving on the expiry cycle takes priority over the timeout.
            ST_ID_HI, ST_ID_LO, ST_D_HI, ST_D_LO: begin
                if (rx_valid) begin
                    case (r_state)
                        ST_ID_HI: begin
                            w_id_nxt    = {rx_data, r_id[7:0]};
                            w_state_nxt = ST_ID_LO;
                        end
                        ST_ID_LO: begin
                            w_id_nxt    = {r_id[15:8], rx_data};
                            w_state_nxt = r_is_wr ? ST_D_HI : ST_EXEC;
                        end
                        ST_D_HI: begin
                            w_wdata_nxt = {rx_data, r_wdata[7:0]};
                            w_state_nxt = ST_D_LO;
                        end
                        default: begin
                            w_wdata_nxt = {r_wdata[15:8], rx_data};
                            w_state_nxt = ST_EXEC;
                        end
                    endcase
                end else if (w_expired) begin
                    w_error_nxt = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EXEC: begin
                w_tx_valid_nxt = 1'b1;
                if (r_is_wr) begin
                    w_tx_data_nxt = ACK_BYTE;
                    w_state_nxt   = ST_TX_RSP;
                end else begin
                    w_held_nxt    = rdata;
                    w_tx_data_nxt = rdata[15:8];
                    w_state_nxt   = ST_TX_HI;
                end
            end
            ST_TX_HI: begin
                if (w_tx_done) begin
                    w_tx_data_nxt = r_held[7:0];
                    w_state_nxt   = ST_TX_LO;
                end
            end
            ST_TX_LO, ST_TX_RSP: begin
                if (w_tx_done) begin
                    w_tx_valid_nxt = 1'b0;
                    w_state_nxt    = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign read     = (r_state == ST_EXEC) && !r_is_wr;
    assign write    = (r_state == ST_EXEC) &&  r_is_wr;
    assign id       = r_id;
    assign wdata    = r_wdata;
    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign error    = r_error;
    assign overrun  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_host_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_host_reg_bridge
// Description : Directed self-checking bench for host_reg_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_host_reg_bridge;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] id;
    logic        read;
    logic        write;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        error;
    logic        overrun;

    int total = 0;
    int bad   = 0;

    int rd_cnt = 0;
    int wr_cnt = 0;
    int err_cnt = 0;
    int tx_n = 0;
    logic both_seen = 1'b0;
    logic [7:0] txq [0:63];

    host_reg_bridge #(
        .TIMEOUT_CYCLES (100),
        .ACK_BYTE       (8'h06),
        .NAK_BYTE       (8'h15)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .id       (id),
        .read     (read),
        .write    (write),
        .wdata    (wdata),
        .rdata    (rdata),
        .error    (error),
        .overrun  (overrun)
    );

    // Register mux model: only a few ids carry meaningful data.
    assign rdata = (id == 16'h0005) ? 16'hA1B2 :
                   (id == 16'h0003) ? 16'h0C33 : 16'hDEAD;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (read)  rd_cnt  <= rd_cnt + 1;
        if (write) wr_cnt  <= wr_cnt + 1;
        if (error) err_cnt <= err_cnt + 1;
        if (read && write) both_seen <= 1'b1;
        if (tx_valid && tx_ready && !reset && tx_n < 64) begin
            txq[tx_n] <= tx_data;
            tx_n      <= tx_n + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; presents one byte for exactly one cycle.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int b_rd, b_wr, b_err, b_tx;
    logic stable;

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        settle(3);
        check_eq("rst_txv",   tx_valid, 0);
        check_eq("rst_txd",   tx_data,  0);
        check_eq("rst_rw",    {read, write, error}, 0);
        check_eq("rst_ovr",   overrun,  0);
        check_eq("rst_id",    id,       0);
        check_eq("rst_wdata", wdata,    0);
        reset = 1'b0;
        settle(2);

        // Read of id 5
        b_rd = rd_cnt; b_wr = wr_cnt; b_tx = tx_n;
        send(8'h52); send(8'h00); send(8'h05);
        @(negedge clk);
        check_eq("rd_strobe", read,  1);
        check_eq("rd_id",     id,    16'h0005);
        check_eq("rd_nowr",   write, 0);
        @(negedge clk);
        check_eq("rd_lat_txv", tx_valid, 1);
        check_eq("rd_1cyc",    read,     0);
        settle(8);
        check_eq("rd_ntx",  tx_n - b_tx, 2);
        check_eq("rd_b0",   txq[b_tx],     8'hA1);
        check_eq("rd_b1",   txq[b_tx + 1], 8'hB2);
        check_eq("rd_cnt",  rd_cnt - b_rd, 1);
        check_eq("rd_wcnt", wr_cnt - b_wr, 0);

        // Write 0x1234 to id 1
        b_rd = rd_cnt; b_wr = wr_cnt; b_tx = tx_n;
        send(8'h57); send(8'h00); send(8'h01); send(8'h12); send(8'h34);
        @(negedge clk);
        check_eq("wr_strobe", write, 1);
        check_eq("wr_id",     id,    16'h0001);
        check_eq("wr_data",   wdata, 16'h1234);
        check_eq("wr_nord",   read,  0);
        settle(8);
        check_eq("wr_ntx",  tx_n - b_tx, 1);
        check_eq("wr_ack",  txq[b_tx], 8'h06);
        check_eq("wr_cnt",  wr_cnt - b_wr, 1);
        check_eq("wr_hold", {id, wdata}, {16'h0001, 16'h1234});

        // Backpressure on a read response
        b_tx = tx_n;
        tx_ready = 1'b0;
        send(8'h52); send(8'h00); send(8'h05);
        @(negedge clk);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!(tx_valid === 1'b1 && tx_data === 8'hA1)) stable = 1'b0;
        end
        check_eq("bp_stable", stable, 1);
        check_eq("bp_none",   tx_n - b_tx, 0);
        @(posedge clk); #1;
        tx_ready = 1'b1;
        settle(8);
        check_eq("bp_ntx", tx_n - b_tx, 2);
        check_eq("bp_b0",  txq[b_tx],     8'hA1);
        check_eq("bp_b1",  txq[b_tx + 1], 8'hB2);

        // Unknown opcode
        b_err = err_cnt; b_tx = tx_n;
        send(8'h41);
        @(negedge clk);
        check_eq("nak_err", error,   1);
        check_eq("nak_txd", tx_data, 8'h15);
        @(negedge clk);
        check_eq("nak_err_1cyc", error, 0);
        settle(4);
        check_eq("nak_ecnt", err_cnt - b_err, 1);
        check_eq("nak_ntx",  tx_n - b_tx, 1);
        check_eq("nak_byte", txq[b_tx], 8'h15);
        b_tx = tx_n;
        send(8'h52); send(8'h00); send(8'h05);
        settle(8);
        check_eq("nak_rd_ntx", tx_n - b_tx, 2);
        check_eq("nak_rd_b0",  txq[b_tx], 8'hA1);

        // Inter-byte timeout
        b_err = err_cnt; b_rd = rd_cnt; b_tx = tx_n;
        send(8'h52); send(8'h00);
        settle(98);
        check_eq("to_early", err_cnt - b_err, 0);
        settle(10);
        check_eq("to_err",  err_cnt - b_err, 1);
        check_eq("to_nord", rd_cnt - b_rd, 0);
        check_eq("to_notx", tx_n - b_tx, 0);
        b_tx = tx_n;
        send(8'h52); send(8'h00); send(8'h03);
        @(negedge clk);
        check_eq("to_rd_id", {read, id}, {1'b1, 16'h0003});
        settle(8);
        check_eq("to_rd_ntx", tx_n - b_tx, 2);
        check_eq("to_rd_b0",  txq[b_tx],     8'h0C);
        check_eq("to_rd_b1",  txq[b_tx + 1], 8'h33);

        // Overrun during TX_HI, then reset mid-transmit
        b_tx = tx_n;
        tx_ready = 1'b0;
        send(8'h52); send(8'h00); send(8'h05);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        send(8'hFF);
        @(negedge clk);
        check_eq("ovr_set",  overrun, 1);
        check_eq("ovr_txd",  tx_data, 8'hA1);
        check_eq("ovr_txv",  tx_valid, 1);
        #2 reset = 1'b1;
        #1;
        check_eq("rst_async_txv", tx_valid, 0);
        check_eq("rst_async_ovr", overrun,  0);
        @(posedge clk); #1;
        reset    = 1'b0;
        tx_ready = 1'b1;
        settle(3);
        check_eq("rst_idle_txv", tx_valid, 0);
        check_eq("rst_notx",     tx_n - b_tx, 0);
        send(8'h57); send(8'h00); send(8'h02); send(8'hAB); send(8'hCD);
        @(negedge clk);
        check_eq("post_rst_wr", {write, id, wdata}, {1'b1, 16'h0002, 16'hABCD});
        settle(6);

        check_eq("never_both", both_seen, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
